// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer feeding the accumulator/ALU stage.
// Memory requests, addresses, ALU pulses and halted are registered.
module instr_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       IR_out,
    output logic [15:0]       BR_out,
    output logic [ADDR_W-1:0] PC_out,
    output logic [9:0]        alu_c,
    input  logic [15:0]       ACC_in,
    input  logic [3:0]        ALUflags,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;

    localparam logic [9:0] ALU_LOAD = 10'b0010000000;
    localparam logic [9:0] ALU_ADD  = 10'b0000000010;
    localparam logic [9:0] ALU_SUB  = 10'b0000000001;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [15:0]       ir, ir_nx;
    logic [15:0]       br, br_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [9:0]        alu_nx;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] opnd_addr;
    logic              sf;
    logic              unused_flags;

    assign opcode       = ir[15:8];
    assign opnd_addr    = ir[ADDR_W-1:0];
    assign sf           = ALUflags[0];
    assign unused_flags = ^ALUflags[3:1];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        br_nx    = br;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nx    = START_PC;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_nx    = mem_rdata;
                    pc_nx    = pc + 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_STORE:                 state_nx = S_STORE;
                    OP_LOAD, OP_ADD, OP_SUB:  state_nx = S_OPERAND;
                    OP_JMPGEZ: begin
                        if (!sf) pc_nx = opnd_addr;
                        state_nx = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_nx    = opnd_addr;
                        state_nx = S_FETCH;
                    end
                    OP_HALT:                  state_nx = S_HALT;
                    default:                  state_nx = S_FETCH;
                endcase
            end
            S_OPERAND: begin
                if (mem_ready) begin
                    br_nx    = mem_rdata;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC:  state_nx = S_FETCH;
            S_STORE: if (mem_ready) state_nx = S_FETCH;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they register cleanly
    always_comb begin
        addr_nx = mem_addr;
        case (state_nx)
            S_FETCH:            addr_nx = pc_nx;
            S_OPERAND, S_STORE: addr_nx = opnd_addr;
            default:            addr_nx = mem_addr;
        endcase
        alu_nx = '0;
        if (state_nx == S_EXEC) begin
            case (opcode)
                OP_LOAD: alu_nx = ALU_LOAD;
                OP_ADD:  alu_nx = ALU_ADD;
                OP_SUB:  alu_nx = ALU_SUB;
                default: alu_nx = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= S_IDLE;
            pc       <= START_PC;
            ir       <= '0;
            br       <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            alu_c    <= '0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            br       <= br_nx;
            mem_addr <= addr_nx;
            mem_rd   <= (state_nx == S_FETCH) || (state_nx == S_OPERAND);
            mem_wr   <= (state_nx == S_STORE);
            alu_c    <= alu_nx;
            halted   <= (state_nx == S_HALT);
        end
    end

    assign mem_wdata = mem_wr ? ACC_in : 16'h0000;
    assign IR_out    = ir;
    assign BR_out    = br;
    assign PC_out    = pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ISA-level model predicts the memory/ALU
// event trace; a per-cycle monitor checks the DUT against it.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] IR_out;
    logic [15:0] BR_out;
    logic [7:0]  PC_out;
    logic [9:0]  alu_c;
    logic [15:0] ACC_in;
    logic [3:0]  ALUflags;
    logic        halted;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(8), .START_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .IR_out(IR_out), .BR_out(BR_out),
        .PC_out(PC_out), .alu_c(alu_c), .ACC_in(ACC_in),
        .ALUflags(ALUflags), .halted(halted)
    );

    // Environment: program memory, wait-state generator, accumulator stage
    logic [15:0] mem [256];
    logic        wait_en;
    logic        force_low;
    int          wcnt;
    logic [15:0] acc;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = force_low ? 1'b0 : (wait_en ? (wcnt == 3) : 1'b1);
    assign ACC_in    = acc;
    assign ALUflags  = {acc == 16'h0, 2'b00, acc[15]};

    always @(posedge clk) begin
        if (rst || !(mem_rd || mem_wr) || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        if (rst) acc <= 16'h0;
        else if (alu_c == 10'h080) acc <= BR_out;
        else if (alu_c == 10'h002) acc <= acc + BR_out;
        else if (alu_c == 10'h001) acc <= acc - BR_out;
    end

    int n_tests = 0;
    int n_fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ISA-level model: architectural PC/ACC and the ordered event trace
    localparam int EV_RD = 0, EV_WR = 1, EV_ALU = 2;
    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;
    ev_t exp_q[$];

    logic [7:0]  m_pc;
    logic [15:0] m_acc;
    logic [15:0] m_store;
    int          m_cycles;
    int          m_nreq;

    task automatic push_ev(input int k, input logic [7:0] a,
                           input logic [15:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
        if (k != EV_ALU) m_nreq++;
    endtask

    task automatic model_run();
        logic [15:0] ir, opnd;
        logic [7:0]  a;
        m_cycles = 0;
        m_nreq   = 0;
        for (int n = 0; n < 200; n++) begin
            ir = mem[m_pc];
            a  = ir[7:0];
            push_ev(EV_RD, m_pc, 16'h0);
            m_pc = m_pc + 8'd1;
            m_cycles += 2;
            if (ir[15:8] == 8'h07) break;
            case (ir[15:8])
                8'h01: begin
                    push_ev(EV_WR, a, m_acc);
                    m_store = m_acc;
                    m_cycles += 1;
                end
                8'h02, 8'h03, 8'h04: begin
                    push_ev(EV_RD, a, 16'h0);
                    opnd = mem[a];
                    m_cycles += 2;
                    if (ir[15:8] == 8'h02) begin
                        push_ev(EV_ALU, 8'h0, 16'h080);
                        m_acc = opnd;
                    end else if (ir[15:8] == 8'h03) begin
                        push_ev(EV_ALU, 8'h0, 16'h002);
                        m_acc = m_acc + opnd;
                    end else begin
                        push_ev(EV_ALU, 8'h0, 16'h001);
                        m_acc = m_acc - opnd;
                    end
                end
                8'h05: if (!m_acc[15]) m_pc = a;
                8'h06: m_pc = a;
                default: ;
            endcase
        end
    endtask

    // Per-cycle monitor
    logic        chk_en;
    logic        prev_hold;
    logic [1:0]  prev_req;
    logic [7:0]  prev_addr;
    logic [7:0]  prev_pc;
    logic [15:0] prev_ir;
    logic        prev_rdrdy;

    task automatic take_ev(input int k, input logic [7:0] a,
                           input logic [15:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(k) + 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", k, e.kind);
            if (k != EV_ALU) chk("ev_addr", a, e.addr);
            if (k != EV_RD) chk("ev_data", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_wr_excl", mem_rd & mem_wr, 0);
            if (prev_hold) begin
                chk("hold_req", {mem_rd, mem_wr}, prev_req);
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_pc", PC_out, prev_pc);
                chk("hold_ir", IR_out, prev_ir);
            end
            if (IR_out != prev_ir) chk("ir_only_on_ready", prev_rdrdy, 1);
            if (mem_ready && mem_rd) take_ev(EV_RD, mem_addr, 16'h0);
            if (mem_ready && mem_wr) take_ev(EV_WR, mem_addr, mem_wdata);
            if (alu_c != 10'h0) take_ev(EV_ALU, 8'h0, {6'h0, alu_c});
        end
        prev_hold  <= (mem_rd || mem_wr) && !mem_ready;
        prev_req   <= {mem_rd, mem_wr};
        prev_addr  <= mem_addr;
        prev_pc    <= PC_out;
        prev_ir    <= IR_out;
        prev_rdrdy <= mem_rd && mem_ready;
    end

    task automatic load_a();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h00] = 16'h0205;
        mem[8'h01] = 16'h0306;
        mem[8'h02] = 16'h0107;
        mem[8'h03] = 16'h0700;
        mem[8'h05] = 16'h0003;
        mem[8'h06] = 16'h0004;
    endtask

    task automatic load_b();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h00] = 16'h0520;
        mem[8'h20] = 16'hFF33;
        mem[8'h21] = 16'h0260;
        mem[8'h22] = 16'h06FF;
        mem[8'hFF] = 16'h0600;
        mem[8'h01] = 16'h0107;
        mem[8'h02] = 16'h0700;
        mem[8'h60] = 16'hFFFF;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_pc   = 8'h00;
        m_acc  = 16'h0;
        exp_q.delete();
    endtask

    task automatic run_prog(input bit glitch, output int lat);
        int cyc;
        chk_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_halted_clr", halted, 0);
        chk("start_fetch_rd", mem_rd, 1);
        chk("start_fetch_addr", mem_addr, 8'h00);
        cyc = 1;
        while (!halted && cyc < 1000) begin
            start = glitch && (cyc == 2);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("halt_reached", halted, 1);
        lat = cyc - 1;
        chk("trace_drained", exp_q.size(), 0);
        chk("final_pc", PC_out, m_pc);
    endtask

    int lat;
    int cnt;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        wait_en   = 1'b0;
        force_low = 1'b0;
        chk_en    = 1'b0;
        load_a();
        do_reset();

        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pc", PC_out, 8'h00);
        chk("rst_ir", IR_out, 0);
        chk("rst_br", BR_out, 0);
        chk("rst_alu_c", alu_c, 0);
        chk("rst_halted", halted, 0);

        // Program A: LOAD 5, ADD 6, STORE 7, HALT
        model_run();
        chk("model_a_cycles", m_cycles, 13);
        chk("model_a_pc", m_pc, 8'h04);
        chk("model_a_store", m_store, 16'h0007);
        run_prog(1'b0, lat);
        chk("a_latency", lat, m_cycles);
        chk("a_pc_literal", PC_out, 8'h04);

        // HALT then start: reload START_PC, rerun A without reset
        m_pc = 8'h00;
        model_run();
        run_prog(1'b0, lat);
        chk("a2_latency", lat, m_cycles);

        // Program B: JMPGEZ both ways, NOP 0xFF, JMP wrap through FF
        load_b();
        do_reset();
        model_run();
        chk("model_b_cycles", m_cycles, 19);
        chk("model_b_pc", m_pc, 8'h03);
        chk("model_b_store", m_store, 16'hFFFF);
        chk("model_b_nreq", m_nreq, 10);
        run_prog(1'b0, lat);
        chk("b_latency", lat, m_cycles);

        // Program B with 3 wait states per request and start during FETCH
        do_reset();
        wait_en = 1'b1;
        model_run();
        run_prog(1'b1, lat);
        chk("b_wait_latency", lat, m_cycles + 3 * m_nreq);

        // Reset in the middle of a stalled OPERAND read
        load_a();
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(mem_rd && mem_addr == 8'h05) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        force_low = 1'b1;
        chk("operand_reached", mem_rd && mem_addr == 8'h05, 1);
        @(negedge clk);
        @(negedge clk);
        chk("stall_pc", PC_out, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_rd", mem_rd, 0);
        chk("midrst_mem_wr", mem_wr, 0);
        chk("midrst_pc", PC_out, 8'h00);
        chk("midrst_ir", IR_out, 0);
        chk("midrst_alu_c", alu_c, 0);
        chk("midrst_halted", halted, 0);
        rst       = 1'b0;
        force_low = 1'b0;
        wait_en   = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute control sequencer sitting directly upstream of the accumulator/ALU stage.
- Fetches 16-bit instructions from a word-addressed memory port and latches IR and BR.
- Generates the one-cycle ALU op-control pulses (C8..C21) that the accumulator stage consumes, and writes the accumulator back to memory on STORE.
- Tracks PC and halts on HALT.

Parameters:
- START_PC, 8'h00, PC value loaded on reset and on start.
- ADDR_W, 8, memory address width (PC and IR operand field).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; synchronous, active-high (asserted when 1).
- start  input  1  in IDLE/HALT: load START_PC, begin fetching.
- mem_addr  output  ADDR_W  memory word address.
- mem_rd  output  1  read request, held until mem_ready.
- mem_wr  output  1  write request, held until mem_ready.
- mem_wdata  output  16  write data (= ACC_in while mem_wr).
- mem_rdata  input  16  read data, valid when mem_ready.
- mem_ready  input  1  completes the current rd/wr in the same cycle.
- IR_out  output  16  instruction register; [15:8] opcode, [7:0] operand address.
- BR_out  output  16  buffer register (operand data) to ALU BR_in.
- PC_out  output  ADDR_W  program counter.
- alu_c  output  10  ALU controls: [0]=C8 [1]=C9 [2]=C13 [3]=C15 [4]=C16 [5]=C17 [6]=C18 [7]=C19 [8]=C20 [9]=C21.
- ACC_in  input  16  current accumulator value.
- ALUflags  input  4  {ZF,CF,OF,SF}; SF = bit 0.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (rst_n=1 at clk edge): state=IDLE, PC=START_PC, IR=0, BR=0, alu_c=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, halted=0.
- Reset has priority over every state, including mid-transfer; any pending request drops the next cycle.
- alu_c is zero in every state except EXEC. alu_c=0 is the ACC-hold operation.
- States and transitions:
  - IDLE:
    - start → FETCH.
  - FETCH:
    - mem_rd=1, mem_addr=PC.
    - On mem_ready: IR<=mem_rdata, PC<=PC+1 (wraps 8'hFF→8'h00), → DECODE.
  - DECODE (1 cycle), by IR[15:8]:
    - 01 STORE → STORE.
    - 02 LOAD, 03 ADD, 04 SUB → OPERAND.
    - 05 JMPGEZ: if SF==0, PC<=IR[7:0]; → FETCH.
    - 06 JMP: PC<=IR[7:0]; → FETCH.
    - 07 HALT → HALT.
    - Any other opcode is a NOP → FETCH.
  - OPERAND:
    - mem_rd=1, mem_addr=IR[7:0].
    - On mem_ready: BR<=mem_rdata, → EXEC.
  - EXEC (exactly 1 cycle):
    - LOAD: alu_c=10'b0010000000 (C19).
    - ADD: alu_c=10'b0000000010 (C9).
    - SUB: alu_c=10'b0000000001 (C8).
    - → FETCH.
    - The accumulator latches the result at the end of EXEC; flags are valid from the following cycle.
  - STORE:
    - mem_wr=1, mem_addr=IR[7:0], mem_wdata=ACC_in.
    - On mem_ready → FETCH.
  - HALT:
    - halted=1.
    - start → PC<=START_PC, halted<=0, → FETCH.
- Memory signals:
  - mem_rd/mem_wr are registered outputs, never both high.
  - mem_addr is stable while a request is held.
  - mem_ready outside a request is ignored.
- Latency with mem_ready tied high:
  - LOAD/ADD/SUB: 4 cycles (FETCH, DECODE, OPERAND, EXEC).
  - STORE: 3 cycles.
  - JMP/JMPGEZ/NOP: 2 cycles.
- JMPGEZ samples ALUflags in DECODE. The flags reflect the last EXEC, because at least FETCH separates them.
- start is ignored in all states except IDLE and HALT.
- IR_out and BR_out hold their values until overwritten.

Test Plan:
- Reset mid-OPERAND with mem_ready held low → next cycle state IDLE, mem_rd=0, PC=0, IR=0, alu_c=0.
- Program at 0: 0205 (LOAD 5), 0306 (ADD 6), 0107 (STORE 7), 0700 (HALT); mem[5]=0003, mem[6]=0004; ready tied high; start pulse:
  - alu_c pulses C19 then C9, one cycle each.
  - mem_wr at addr 07 carries wdata=ACC_in.
  - halted=1 with PC=04.
- Wait states: mem_ready low for 3 cycles during FETCH → mem_rd and mem_addr held constant; IR updates only on the ready cycle; PC increments exactly once.
- JMPGEZ 0x20 with SF=1 → PC stays at the incremented value. With SF=0 → next fetch at address 0x20. JMP 0x00 issued from PC=FF (after increment PC=00) → fetch at 00, checking wrap.
- Opcode 0xFF → treated as NOP: no mem_rd to the operand address, alu_c stays 0, next FETCH at PC+1. start asserted during FETCH → ignored.
- HALT then start → PC reloaded to START_PC, halted deasserts, fetch restarts.
